mul_seq: RTL and testbench
==========================

# mul_seq

Sequencer between the CPU datapath and the 4x4 shift-and-add multiply unit. It latches two 4-bit operands on a start request and drives the multiplier's operand-load, nibble-select, data and step-clock inputs through a fixed schedule. It then reads back the 8-bit product as two nibbles and presents it to the CPU with a busy/done handshake. It is the only block that drives the multiplier's `DIN0..3`, `LOAD`, `RSEL` and `MUL_CLK` inputs.

## Interface
- `PULSES`, 5: number of `MUL_CLK` high pulses issued per multiply; must be >= 4 (the multiplier self-stops after 4 steps).
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  request; accepted only in IDLE.
- `OPA`  in  4  multiplicand, sampled on the accepting edge.
- `OPB`  in  4  multiplier, sampled on the accepting edge.
- `BUSY`  out  1  high from the accepting edge until DONE is entered.
- `DONE`  out  1  one-cycle pulse when `RESULT` becomes valid.
- `RESULT`  out  8  product; holds until the next DONE.
- `M_DIN`  out  4  to multiplier `DIN3..DIN0`.
- `M_LOAD`  out  1  to multiplier `LOAD`.
- `M_RSEL`  out  1  to multiplier `RSEL`.
- `M_CLK`  out  1  to multiplier `MUL_CLK`.
- `M_R`  in  4  from multiplier `R3..R0`.

## Operation
- All multiplier-facing outputs are registered Moore outputs, decoded from the state register. `M_CLK` comes straight from a flop and must be glitch-free.
- Operand latches: `a_q` and `b_q` load on the accepting edge.
- States and what each one does:
  - IDLE: all `M_*` outputs are 0.
    - `START` = 1 → LOAD_B; `BUSY` rises.
  - LOAD_B: `M_LOAD` = 1, `M_RSEL` = 0, `M_DIN` = `b_q`.
    - Loads the multiplier register and clears the accumulator.
    - Next state: LOAD_A.
  - LOAD_A: `M_LOAD` = 1, `M_RSEL` = 1, `M_DIN` = `a_q`.
    - Loads the multiplicand and clears the step counter.
    - Next state: RUN.
  - RUN: `M_LOAD` = 0, `M_RSEL` = 0.
    - `M_CLK` is 1 on RUN cycles 0, 2, 4, … and 0 on odd cycles.
    - Lasts 2·`PULSES` cycles, counted by an internal `run_cnt`.
    - Next state: READ_LO.
  - READ_LO: `M_RSEL` = 1 (`M_R` shows product bits 3:0).
    - Capture `M_R` into `res_q[3:0]` at the exit edge.
    - Next state: READ_HI.
  - READ_HI: `M_RSEL` = 0 (`M_R` shows bits 7:4).
    - Capture `M_R` into `res_q[7:4]`.
    - Next state: DONE.
  - DONE: `DONE` = 1, `BUSY` = 0, `RESULT` = `res_q`.
    - Next state: IDLE, unconditionally.
- `START` outside IDLE is ignored: no queueing and no error. `START` held high across DONE is accepted again on the IDLE edge.
- `RESULT` register updates only on the READ_LO/READ_HI capture edges, or on the bypass edge. Between multiplies it holds the last product.
- Arithmetic: the product is unsigned, 4 × 4 → 8 bits. Maximum is 15 × 15 = 225 = 0xE1. No overflow is possible.

## Timing
- Reset values: state IDLE; `BUSY` = 0, `DONE` = 0, `RESULT` = 0x00, `M_DIN` = 0, `M_LOAD` = 0, `M_RSEL` = 0, `M_CLK` = 0; `run_cnt` = 0.
- Latency: accepting edge = E0.
  - LOAD_B in cycle E0+1, LOAD_A in E0+2.
  - RUN from E0+3 for 2·`PULSES` cycles.
  - READ_LO, READ_HI, then `DONE` high in cycle E0+5+2·`PULSES` (15 at default).
- `BUSY` is high for exactly 4+2·`PULSES` cycles per multiply.
- Back-to-back throughput: one product per 6+2·`PULSES` cycles.
- `M_LOAD` is never high while `M_CLK` is high. `M_CLK` is 0 on entry to and exit from RUN.
- Reset mid-operation (any state) returns to reset values on that edge. `M_CLK` drops to 0 that same edge.
  - The multiplier's partial state is discarded; the next multiply reloads everything.
- `RST` and `START` both high: reset wins and `START` is dropped.

## Configuration
- `MUL_SEQ_ZERO_BYPASS_EN`
  - Defined: on an accepting edge where `OPA` == 0 or `OPB` == 0, go directly IDLE → DONE.
    - `RESULT` = 0x00 is captured on that edge; `DONE` is high in cycle E0+1.
    - No `M_*` activity occurs; `BUSY` stays 0.
  - Undefined: zero operands take the full schedule; the result is still 0x00.

## Test plan
- Reset, then `OPA` = 7, `OPB` = 6, `START` one cycle → `BUSY` high for 14 cycles, `DONE` pulse at E0+15, `RESULT` = 0x2A; exactly 5 `M_CLK` pulses.
- `OPA` = 15, `OPB` = 15 → `RESULT` = 0xE1. Then `OPA` = 1, `OPB` = 1 back-to-back with `START` held high → second `DONE` 16 cycles after the first, `RESULT` = 0x01.
- `START` pulsed during RUN → ignored: no extra `DONE`, `RESULT` unchanged, schedule length unchanged.
- `RST` asserted in RUN cycle 3 → next cycle all outputs 0, `RESULT` = 0x00. A fresh 3 × 5 multiply then yields 0x0F.
- `OPA` = 0, `OPB` = 9:
  - With `MUL_SEQ_ZERO_BYPASS_EN`: `DONE` at E0+1, no `M_LOAD`/`M_CLK` toggles.
  - Without it: `DONE` at E0+15, `RESULT` = 0x00.
- Protocol checker over every run:
  - `M_LOAD` high only in LOAD states.
  - `M_CLK` and `M_LOAD` never both high.
  - `M_RSEL` = 1 exactly in LOAD_A and READ_LO.

Source files
------------

// File: rtl/mul_seq.sv
// Sequencer driving the 4x4 shift-and-add multiplier: operand load, stepping, product readback.
// Optional MUL_SEQ_ZERO_BYPASS_EN: zero operands skip the multiplier and finish in one cycle.
module mul_seq #(
    parameter int unsigned PULSES = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] OPA,
    input  logic [3:0] OPB,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic [3:0] M_DIN,
    output logic       M_LOAD,
    output logic       M_RSEL,
    output logic       M_CLK,
    input  logic [3:0] M_R
);

    localparam int unsigned RUN_LEN = 2 * PULSES;
    localparam int unsigned CW      = $clog2(RUN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_LOAD_A,
        S_RUN,
        S_READ_LO,
        S_READ_HI,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      a_q, a_d;
    logic [3:0]      b_q, b_d;
    logic [CW-1:0]   run_cnt_q, run_cnt_d;
    logic [7:0]      res_q, res_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      m_din_q, m_din_d;
    logic            m_load_q, m_load_d;
    logic            m_rsel_q, m_rsel_d;
    logic            m_clk_q, m_clk_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            run_cnt_q <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_din_q   <= '0;
            m_load_q  <= 1'b0;
            m_rsel_q  <= 1'b0;
            m_clk_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            run_cnt_q <= run_cnt_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            m_din_q   <= m_din_d;
            m_load_q  <= m_load_d;
            m_rsel_q  <= m_rsel_d;
            m_clk_q   <= m_clk_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        run_cnt_d = run_cnt_q;
        res_d     = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d     = OPA;
                    b_d     = OPB;
                    state_d = S_LOAD_B;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
                    if ((OPA == 4'd0) || (OPB == 4'd0)) begin
                        state_d = S_DONE;
                        res_d   = '0;
                    end
`endif
                end
            end
            S_LOAD_B: state_d = S_LOAD_A;
            S_LOAD_A: begin
                state_d   = S_RUN;
                run_cnt_d = '0;
            end
            S_RUN: begin
                if (run_cnt_q == CW'(RUN_LEN - 1)) begin
                    state_d = S_READ_LO;
                end else begin
                    run_cnt_d = run_cnt_q + CW'(1);
                end
            end
            S_READ_LO: begin
                res_d[3:0] = M_R;
                state_d    = S_READ_HI;
            end
            S_READ_HI: begin
                res_d[7:4] = M_R;
                state_d    = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop
    // while still lining up with the state it belongs to.
    always_comb begin
        m_din_d  = '0;
        m_load_d = 1'b0;
        m_rsel_d = 1'b0;
        m_clk_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            S_LOAD_B: begin
                m_load_d = 1'b1;
                m_din_d  = b_d;
                busy_d   = 1'b1;
            end
            S_LOAD_A: begin
                m_load_d = 1'b1;
                m_rsel_d = 1'b1;
                m_din_d  = a_d;
                busy_d   = 1'b1;
            end
            S_RUN: begin
                m_clk_d = ~run_cnt_d[0];
                busy_d  = 1'b1;
            end
            S_READ_LO: begin
                m_rsel_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_READ_HI: busy_d = 1'b1;
            S_DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = res_q;
    assign M_DIN  = m_din_q;
    assign M_LOAD = m_load_q;
    assign M_RSEL = m_rsel_q;
    assign M_CLK  = m_clk_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq with a behavioural 4x4 multiplier model on the M_* pins.
module tb_mul_seq;

    localparam int unsigned P = 5;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] OPA;
    logic [3:0] OPB;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic [3:0] M_DIN;
    logic       M_LOAD;
    logic       M_RSEL;
    logic       M_CLK;
    logic [3:0] M_R;

    int checks = 0;
    int errors = 0;

    mul_seq #(.PULSES(P)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OPA(OPA), .OPB(OPB),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
        .M_DIN(M_DIN), .M_LOAD(M_LOAD), .M_RSEL(M_RSEL), .M_CLK(M_CLK), .M_R(M_R)
    );

    always #5 CLK = ~CLK;

    // Multiplier model: product is valid once four step pulses have been seen after loading A.
    logic [3:0] mdl_a = '0;
    logic [3:0] mdl_b = '0;
    int         mdl_steps = 0;
    logic       mdl_prev_clk = 1'b0;
    logic [7:0] mdl_prod;

    always @(posedge CLK) begin
        if (M_LOAD && !M_RSEL) mdl_b <= M_DIN;
        if (M_LOAD && M_RSEL) begin
            mdl_a     <= M_DIN;
            mdl_steps <= 0;
        end else if (M_CLK && !mdl_prev_clk && mdl_steps < 4) begin
            mdl_steps <= mdl_steps + 1;
        end
        mdl_prev_clk <= M_CLK;
    end

    assign mdl_prod = (mdl_steps >= 4) ? ({4'd0, mdl_a} * {4'd0, mdl_b}) : 8'h00;
    assign M_R      = M_RSEL ? mdl_prod[3:0] : mdl_prod[7:4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            chk("load_clk_exclusive", {31'd0, M_LOAD & M_CLK}, 32'd0);
            chk("load_implies_busy", {31'd0, M_LOAD & ~BUSY}, 32'd0);
        end
    end

    // One multiply from accept to DONE; returns in the DONE cycle.
    task automatic run_mul(input logic [3:0] a, input logic [3:0] b, input bit hold_start);
        int n, busy_n, pulses, load_n, rsel_n;
        int exp_lat, exp_busy, exp_pulses, exp_sel;
        logic prev;
        exp_lat    = 5 + 2 * P;
        exp_busy   = 4 + 2 * P;
        exp_pulses = P;
        exp_sel    = 2;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
        if (a == 4'd0 || b == 4'd0) begin
            exp_lat = 1; exp_busy = 0; exp_pulses = 0; exp_sel = 0;
        end
`endif
        OPA = a; OPB = b; START = 1'b1;
        cycle();
        if (!hold_start) START = 1'b0;
        n = 1; busy_n = 0; pulses = 0; load_n = 0; rsel_n = 0; prev = 1'b0;
        while (!DONE && n < 60) begin
            busy_n += int'(BUSY);
            load_n += int'(M_LOAD);
            rsel_n += int'(M_RSEL);
            if (M_CLK && !prev) pulses++;
            prev = M_CLK;
            cycle();
            n++;
        end
        chk("latency", n, exp_lat);
        chk("done_high", {31'd0, DONE}, 32'd1);
        chk("busy_low_in_done", {31'd0, BUSY}, 32'd0);
        chk("result", {24'd0, RESULT}, int'(a) * int'(b));
        chk("busy_cycles", busy_n, exp_busy);
        chk("mclk_pulses", pulses, exp_pulses);
        chk("load_cycles", load_n, exp_sel);
        chk("rsel_cycles", rsel_n, exp_sel);
    endtask

    initial begin
        int k, dones;
        logic [7:0] held;
        RST = 1'b1; START = 1'b0; OPA = '0; OPB = '0;
        cycle(); cycle();
        chk("reset_outputs", {17'd0, BUSY, DONE, RESULT, M_DIN, M_LOAD, M_RSEL, M_CLK}, 32'd0);
        RST = 1'b0;
        cycle();

        run_mul(4'd7, 4'd6, 1'b0);
        chk("7x6", {24'd0, RESULT}, 32'h2A);
        cycle();
        chk("done_one_cycle", {31'd0, DONE}, 32'd0);

        // Back-to-back with START held: next DONE one full period after the first.
        run_mul(4'd15, 4'd15, 1'b1);
        chk("15x15", {24'd0, RESULT}, 32'hE1);
        OPA = 4'd1; OPB = 4'd1;
        cycle();
        k = 1;
        while (!DONE && k < 60) begin
            cycle();
            k++;
        end
        START = 1'b0;
        chk("b2b_period", k, 6 + 2 * P);
        chk("1x1", {24'd0, RESULT}, 32'h01);
        cycle();

        // START during RUN is ignored.
        OPA = 4'd9; OPB = 4'd11; START = 1'b1;
        cycle();
        START = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        START = 1'b1; OPA = 4'd3; OPB = 4'd3;
        cycle();
        START = 1'b0;
        k = 6;
        while (!DONE && k < 60) begin
            cycle();
            k++;
        end
        chk("ignored_start_latency", k, 5 + 2 * P);
        chk("ignored_start_result", {24'd0, RESULT}, 32'd99);
        held  = RESULT;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            dones += int'(DONE);
        end
        chk("no_extra_done", dones, 0);
        chk("result_holds", {24'd0, RESULT}, {24'd0, held});

        // Reset in RUN cycle 3, with START also high: reset wins.
        OPA = 4'd4; OPB = 4'd9; START = 1'b1;
        cycle();
        START = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        RST = 1'b1; START = 1'b1;
        cycle();
        chk("midrun_reset", {17'd0, BUSY, DONE, RESULT, M_DIN, M_LOAD, M_RSEL, M_CLK}, 32'd0);
        RST = 1'b0; START = 1'b0;
        cycle();
        chk("start_dropped_by_reset", {31'd0, BUSY}, 32'd0);
        run_mul(4'd3, 4'd5, 1'b0);
        chk("3x5", {24'd0, RESULT}, 32'h0F);
        cycle();

        run_mul(4'd0, 4'd9, 1'b0);
        chk("0x9", {24'd0, RESULT}, 32'h00);
        cycle();

        for (int i = 0; i < 8; i++) begin
            run_mul(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
